multdiv_seq: RTL

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_seq.sv | 85 ++++++++
 1 files changed

// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed 32x32 multiply (low word) and restoring divide (quotient),
// each 32 iterations, with an overflow/divide-by-zero code and an instruction tag per result.
module multdiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] instr_in,
  output logic [31:0] p_out,
  output logic        r_out,
  output logic [2:0]  e_out,
  output logic [31:0] instr_out,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;
  state_t      state_q;
  logic [31:0] a_q, b_q, instr_q, amag, dmag, quo_d;
  logic [63:0] acc_q, sh_q, mul_d, div_d;
  logic [32:0] trial, diff;
  logic [5:0]  cnt_q;
  always_comb begin
    amag  = operand_a[31] ? -operand_a : operand_a;
    dmag  = b_q[31] ? -b_q : b_q;
    // bit 31 of the multiplier carries negative weight in two's complement
    mul_d = acc_q + (b_q[cnt_q[4:0]] ? (cnt_q == 6'd31 ? -sh_q : sh_q) : 64'd0);
    trial = {acc_q[63:32], acc_q[31]};
    diff  = trial - {1'b0, dmag};
    div_d = diff[32] ? {trial[31:0], acc_q[30:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
    quo_d = (a_q[31] ^ b_q[31]) ? -acc_q[31:0] : acc_q[31:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      p_out     <= 32'd0;
      e_out     <= 3'b000;
      instr_out <= 32'd0;
      r_out     <= 1'b0;
      busy      <= 1'b0;
      cnt_q     <= 6'd0;
    end else begin
      r_out <= 1'b0;
      case (state_q)
        IDLE: if (ctrl_mult || ctrl_div) begin
          a_q     <= operand_a;
          b_q     <= operand_b;
          instr_q <= instr_in;
          sh_q    <= {{32{operand_a[31]}}, operand_a};
          acc_q   <= ctrl_mult ? 64'd0 : {32'd0, amag};
          cnt_q   <= 6'd0;
          busy    <= 1'b1;
          state_q <= ctrl_mult ? MULT : DIV;
        end
        MULT: if (cnt_q == 6'd32) begin
          p_out     <= acc_q[31:0];
          e_out     <= (acc_q[63:32] != {32{acc_q[31]}}) ? 3'b001 : 3'b000;
          instr_out <= instr_q;
          r_out     <= 1'b1;
          busy      <= 1'b0;
          cnt_q     <= 6'd0;
          state_q   <= IDLE;
        end else begin
          acc_q <= mul_d;
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 6'd1;
        end
        DIV: if (b_q == 32'd0 || cnt_q == 6'd32) begin
          p_out     <= (b_q == 32'd0) ? 32'd0 : quo_d;
          e_out     <= (b_q == 32'd0) ? 3'b010 :
                       (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) ? 3'b001 : 3'b000;
          instr_out <= instr_q;
          r_out     <= 1'b1;
          busy      <= 1'b0;
          cnt_q     <= 6'd0;
          state_q   <= IDLE;
        end else begin
          acc_q <= div_d;
          cnt_q <= cnt_q + 6'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
